// File: rtl/router_fsm_ctrl.sv
// Packet sequencing FSM for the 1x3 router: decodes the header address, drives the
// register-block state strobes and FIFO write enable, and handles full stalls and soft resets.
module router_fsm_ctrl #(
  parameter int              ADDR_W       = 2,
  parameter logic [ADDR_W-1:0] INVALID_ADDR = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [ADDR_W-1:0] dest_addr
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t              state, nxt;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_empty;
  logic                sel_soft;
  logic                hdr_ok;

  // While decoding, the header byte itself selects the FIFO; afterwards the latched address does.
  assign sel_addr = (state == DECODE_ADDRESS) ? data_in : dest_addr;
  assign hdr_ok   = pkt_valid && (data_in != INVALID_ADDR);

  always_comb begin
    sel_empty = 1'b0;
    case (sel_addr)
      2'd0:    sel_empty = fifo_empty_0;
      2'd1:    sel_empty = fifo_empty_1;
      2'd2:    sel_empty = fifo_empty_2;
      default: sel_empty = 1'b0;
    endcase
  end

  always_comb begin
    sel_soft = 1'b0;
    case (dest_addr)
      2'd0:    sel_soft = soft_reset_0;
      2'd1:    sel_soft = soft_reset_1;
      2'd2:    sel_soft = soft_reset_2;
      default: sel_soft = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok) nxt = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       nxt = FIFO_FULL_STATE;
        else if (!pkt_valid) nxt = LOAD_PARITY;
      end
      LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE: begin
        if (!fifo_full) nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        nxt = DECODE_ADDRESS;
        else if (low_pkt_valid) nxt = LOAD_PARITY;
        else                    nxt = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) nxt = LOAD_FIRST_DATA;
      end
      default: nxt = DECODE_ADDRESS;
    endcase
    // A timeout on the FIFO this packet targets abandons the packet from any state.
    if (state != DECODE_ADDRESS && sel_soft) nxt = DECODE_ADDRESS;
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= DECODE_ADDRESS;
      dest_addr     <= '0;
      write_enb_reg <= 1'b0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= nxt;
      if (state == DECODE_ADDRESS && hdr_ok) dest_addr <= data_in;
      write_enb_reg <= (nxt == LOAD_FIRST_DATA) || (nxt == LOAD_DATA) ||
                       (nxt == LOAD_PARITY)     || (nxt == LOAD_AFTER_FULL);
      detect_add    <= (nxt == DECODE_ADDRESS);
      lfd_state     <= (nxt == LOAD_FIRST_DATA);
      ld_state      <= (nxt == LOAD_DATA);
      laf_state     <= (nxt == LOAD_AFTER_FULL);
      full_state    <= (nxt == FIFO_FULL_STATE);
      rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
      busy          <= (nxt != DECODE_ADDRESS) && (nxt != LOAD_DATA);
    end
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl: walks each packet path and compares the
// packed output vector and dest_addr against hand-derived values.
module tb_router_fsm_ctrl;
  logic       clk = 0;
  logic       reset;
  logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
  logic [1:0] dest_addr;
  int checks = 0;
  int failures = 0;

  // {we, detect_add, lfd, ld, laf, full, rst_int, busy}
  localparam logic [7:0] E_DEC = 8'h40, E_LFD = 8'hA1, E_LD  = 8'h90, E_LP  = 8'h81;
  localparam logic [7:0] E_FFS = 8'h05, E_LAF = 8'h89, E_WTE = 8'h01, E_CPE = 8'h03;

  wire [7:0] outs = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};

  always #5 clk = ~clk;

  router_fsm_ctrl dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .dest_addr(dest_addr)
  );

  // Inputs change just after a falling edge; the DUT is sampled at the next falling edge.
  task automatic test_reset;
    reset = 0; pkt_valid = 0; data_in = 0; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    repeat (2) @(negedge clk);
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL reset_outs got=%h exp=%h", outs, E_DEC); end
    checks++; if (dest_addr !== 2'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", dest_addr); end
    reset = 1; pkt_valid = 1; data_in = 2'd1;
    @(negedge clk);
    checks++; if (outs !== E_LFD) begin failures++; $display("FAIL pkt_lfd got=%h exp=%h", outs, E_LFD); end
    checks++; if (dest_addr !== 2'd1) begin failures++; $display("FAIL pkt_dest got=%0d exp=1", dest_addr); end
    data_in = 2'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (outs !== E_LD) begin failures++; $display("FAIL pkt_ld%0d got=%h exp=%h", i, outs, E_LD); end
      if (i == 9) pkt_valid = 0;
    end
    @(negedge clk);
    checks++; if (outs !== E_LP) begin failures++; $display("FAIL pkt_lp got=%h exp=%h", outs, E_LP); end
    @(negedge clk);
    checks++; if (outs !== E_CPE) begin failures++; $display("FAIL pkt_cpe got=%h exp=%h", outs, E_CPE); end
    @(negedge clk);
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL pkt_dec got=%h exp=%h", outs, E_DEC); end
    checks++; if (dest_addr !== 2'd1) begin failures++; $display("FAIL pkt_dest_hold got=%0d exp=1", dest_addr); end
  endtask

  task automatic test_busy_dest;
    fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'd2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) data_in = 2'd0;
      checks++; if (outs !== E_WTE) begin failures++; $display("FAIL wait_c%0d got=%h exp=%h", c, outs, E_WTE); end
    end
    checks++; if (dest_addr !== 2'd2) begin failures++; $display("FAIL wait_dest got=%0d exp=2", dest_addr); end
    fifo_empty_2 = 1;
    @(negedge clk);
    checks++; if (outs !== E_LFD) begin failures++; $display("FAIL wait_lfd got=%h exp=%h", outs, E_LFD); end
    @(negedge clk);
    checks++; if (outs !== E_LD) begin failures++; $display("FAIL wait_ld got=%h exp=%h", outs, E_LD); end
    pkt_valid = 0;
    repeat (3) @(negedge clk);
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL wait_end got=%h exp=%h", outs, E_DEC); end
  endtask

  task automatic test_invalid_addr;
    pkt_valid = 1; data_in = 2'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (outs !== E_DEC) begin failures++; $display("FAIL inv_c%0d got=%h exp=%h", c, outs, E_DEC); end
    end
    checks++; if (dest_addr !== 2'd2) begin failures++; $display("FAIL inv_dest got=%0d exp=2", dest_addr); end
    pkt_valid = 0;
  endtask

  task automatic test_full_stall;
    pkt_valid = 1; data_in = 2'd0;
    @(negedge clk); data_in = 2'd3;
    @(negedge clk);
    checks++; if (outs !== E_LD) begin failures++; $display("FAIL full_ld got=%h exp=%h", outs, E_LD); end
    fifo_full = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (outs !== E_FFS) begin failures++; $display("FAIL full_ffs%0d got=%h exp=%h", c, outs, E_FFS); end
    end
    fifo_full = 0;
    @(negedge clk);
    checks++; if (outs !== E_LAF) begin failures++; $display("FAIL full_laf1 got=%h exp=%h", outs, E_LAF); end
    @(negedge clk);
    checks++; if (outs !== E_LD) begin failures++; $display("FAIL full_back_ld got=%h exp=%h", outs, E_LD); end
    fifo_full = 1;
    @(negedge clk); fifo_full = 0;
    @(negedge clk);
    checks++; if (outs !== E_LAF) begin failures++; $display("FAIL full_laf2 got=%h exp=%h", outs, E_LAF); end
    low_pkt_valid = 1; pkt_valid = 0;
    @(negedge clk);
    checks++; if (outs !== E_LP) begin failures++; $display("FAIL full_lp got=%h exp=%h", outs, E_LP); end
    low_pkt_valid = 0;
    @(negedge clk);
    checks++; if (outs !== E_CPE) begin failures++; $display("FAIL full_cpe got=%h exp=%h", outs, E_CPE); end
    fifo_full = 1;
    @(negedge clk);
    checks++; if (outs !== E_FFS) begin failures++; $display("FAIL cpe_to_ffs got=%h exp=%h", outs, E_FFS); end
    fifo_full = 0;
    @(negedge clk);
    checks++; if (outs !== E_LAF) begin failures++; $display("FAIL full_laf3 got=%h exp=%h", outs, E_LAF); end
    parity_done = 1;
    @(negedge clk);
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL laf_done got=%h exp=%h", outs, E_DEC); end
    parity_done = 0;
  endtask

  task automatic test_soft_reset;
    pkt_valid = 1; data_in = 2'd0;
    @(negedge clk); data_in = 2'd3;
    @(negedge clk);
    soft_reset_1 = 1;
    @(negedge clk); soft_reset_1 = 0;
    checks++; if (outs !== E_LD) begin failures++; $display("FAIL soft_other got=%h exp=%h", outs, E_LD); end
    soft_reset_0 = 1;
    @(negedge clk); soft_reset_0 = 0;
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL soft_sel got=%h exp=%h", outs, E_DEC); end
    checks++; if (dest_addr !== 2'd0) begin failures++; $display("FAIL soft_dest got=%0d exp=0", dest_addr); end
    pkt_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    pkt_valid = 1; data_in = 2'd2;
    @(negedge clk); data_in = 2'd3;
    @(negedge clk); fifo_full = 1;
    @(negedge clk); fifo_full = 0;
    @(negedge clk);
    checks++; if (outs !== E_LAF) begin failures++; $display("FAIL async_pre got=%h exp=%h", outs, E_LAF); end
    #2 reset = 0;
    #1;
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL async_outs got=%h exp=%h", outs, E_DEC); end
    checks++; if (dest_addr !== 2'd0) begin failures++; $display("FAIL async_dest got=%0d exp=0", dest_addr); end
    pkt_valid = 0;
    @(negedge clk); reset = 1;
    @(negedge clk);
    checks++; if (outs !== E_DEC) begin failures++; $display("FAIL async_after got=%h exp=%h", outs, E_DEC); end
  endtask

  initial begin
    test_reset;
    test_busy_dest;
    test_invalid_addr;
    test_full_stall;
    test_soft_reset;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
